// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph table and display constants for the scan counter
package seg7_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_OFF_HI = 7'h00;
    localparam logic [6:0] SEG_OFF_LO = 7'h7F;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: active-high 7-segment glyph for one hex nibble
import seg7_pkg::*;

module hex_to_seg7 (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_glyph
);

    assign o_glyph = GLYPHS[i_nibble];

endmodule

// File: rtl/seg7_scan_counter.sv
// seg7_scan_counter: prescaled N-digit hex up/down counter with multiplexed 7-segment output
import seg7_pkg::*;

module seg7_scan_counter #(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned TICK_DIV       = 4194304,
    parameter int unsigned SCAN_DIV       = 12000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          LZ_BLANK       = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tick,
    output logic                    wrap,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS || TICK_DIV < 2 || SCAN_DIV < 2) begin : g_bad_params
        $error("seg7_scan_counter: parameter out of range");
    end

    logic [TW-1:0]         r_tick_cnt;
    logic [W-1:0]          r_count;
    logic                  r_tick;
    logic                  r_wrap;
    logic [SW-1:0]         r_scan_cnt;
    logic [IW-1:0]         r_idx;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig;

    logic                  w_tick_term;
    logic                  w_at_edge;
    logic                  w_scan_term;
    logic                  w_slot_blank;
    logic                  w_lz;
    logic [3:0]            w_nib;
    logic [6:0]            w_glyph;
    logic [6:0]            w_seg_off;
    logic [NUM_DIGITS-1:0] w_onehot;

    assign w_tick_term  = en && (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_at_edge    = up_dn ? (&r_count) : (r_count == '0);
    assign w_scan_term  = r_scan_cnt == SW'(SCAN_DIV - 1);
    // Slot position 0 is the anti-ghost blank cycle that follows every index advance
    assign w_slot_blank = r_scan_cnt == '0;
    assign w_nib        = 4'(r_count >> (4 * r_idx));
    assign w_lz         = LZ_BLANK && (r_idx != '0) && ((r_count >> (4 * r_idx)) == '0);
    assign w_seg_off    = SEG_ACTIVE_LOW ? SEG_OFF_LO : SEG_OFF_HI;
    assign w_onehot     = NUM_DIGITS'(1) << r_idx;

    hex_to_seg7 u_dec (
        .i_nibble (w_nib),
        .o_glyph  (w_glyph)
    );

    // Prescaler and counter; load wins over a step and suppresses wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_count    <= '0;
            r_tick     <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_tick     <= w_tick_term;
            r_wrap     <= w_tick_term && !load && w_at_edge;
            r_tick_cnt <= (load || w_tick_term) ? '0 : (en ? r_tick_cnt + 1'b1 : r_tick_cnt);
            r_count    <= load ? load_value : (w_tick_term ? (up_dn ? r_count + 1'b1 : r_count - 1'b1) : r_count);
        end
    end

    // Free-running scan counter stepping the digit index at each slot end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else begin
            r_scan_cnt <= w_scan_term ? '0 : r_scan_cnt + 1'b1;
            if (w_scan_term)
                r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    // Registered display drive: blank cycle, leading-zero blanking, polarity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= w_seg_off;
            r_dig <= '0;
        end else begin
            r_dig <= w_slot_blank ? '0 : w_onehot;
            r_seg <= (w_slot_blank || w_lz) ? w_seg_off : (SEG_ACTIVE_LOW ? ~w_glyph : w_glyph);
        end
    end

    assign count   = r_count;
    assign tick    = r_tick;
    assign wrap    = r_wrap;
    assign seg     = r_seg;
    assign dig_sel = r_dig;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// tb_seg7_scan_counter: randomized check of counter and scan display against an arithmetic model
module tb_seg7_scan_counter;

    localparam int ND = 2;
    localparam int TD = 4;
    localparam int SD = 3;
    localparam int W  = 4 * ND;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic up_dn = 1'b1;
    logic load = 1'b0;
    logic [W-1:0] load_value = '0;

    logic [W-1:0]  count0, count1;
    logic          tick0, tick1, wrap0, wrap1;
    logic [6:0]    seg0, seg1;
    logic [ND-1:0] dig0, dig1;

    int n_checks = 0;
    int n_errors = 0;

    // Model: edges since reset, counter value, prescaler phase, value shown on the display
    int m_n, m_pos, m_cnt, m_p, m_shown;
    bit m_tick, m_wrap;

    logic [6:0] glyph [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    always #5 clk = ~clk;

    seg7_scan_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_value(load_value),
        .count(count0), .tick(tick0), .wrap(wrap0), .seg(seg0), .dig_sel(dig0)
    );

    seg7_scan_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_value(load_value),
        .count(count1), .tick(tick1), .wrap(wrap1), .seg(seg1), .dig_sel(dig1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_pos = 0; m_cnt = 0; m_p = 0; m_shown = 0; m_tick = 0; m_wrap = 0;
    endtask

    task automatic model_edge();
        m_pos   = m_n;
        m_n++;
        m_shown = m_cnt;
        m_tick  = en && (m_p == TD - 1);
        m_wrap  = 1'b0;
        if (load) begin
            m_cnt = int'(load_value);
            m_p   = 0;
        end else if (en) begin
            if (m_p == TD - 1) begin
                m_p    = 0;
                m_wrap = up_dn ? (m_cnt == MASK) : (m_cnt == 0);
                m_cnt  = (m_cnt + (up_dn ? 1 : -1)) & MASK;
            end else begin
                m_p++;
            end
        end
    endtask

    task automatic check_outputs();
        bit blank;
        int idx, nib, upper;
        logic [6:0] e_seg0, e_seg1;
        blank  = (m_pos % SD) == 0;
        idx    = (m_pos / SD) % ND;
        nib    = (m_shown >> (4 * idx)) & 15;
        upper  = m_shown >> (4 * idx);
        e_seg0 = blank ? 7'h7F : ~glyph[nib];
        e_seg1 = (blank || (idx > 0 && upper == 0)) ? 7'h7F : ~glyph[nib];
        check("count", 32'(count0), 32'(m_cnt));
        check("tick", 32'(tick0), 32'(m_tick));
        check("wrap", 32'(wrap0), 32'(m_wrap));
        check("dig_sel", 32'(dig0), blank ? 32'd0 : (32'd1 << idx));
        check("seg", 32'(seg0), 32'(e_seg0));
        check("seg_lz", 32'(seg1), 32'(e_seg1));
        check("dig_sel_lz", 32'(dig1), blank ? 32'd0 : (32'd1 << idx));
    endtask

    task automatic check_reset_values();
        check("rst_count", 32'(count0), 32'd0);
        check("rst_tick", 32'(tick0), 32'd0);
        check("rst_wrap", 32'(wrap0), 32'd0);
        check("rst_seg", 32'(seg0), 32'h7F);
        check("rst_dig_sel", 32'(dig0), 32'd0);
        check("rst_seg_lz", 32'(seg1), 32'h7F);
        check("rst_count_lz", 32'(count1), 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1 check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_values();
        @(posedge clk);
        #1 check_reset_values();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_value_now(input logic [W-1:0] v);
        load = 1'b1; load_value = v;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        do_reset();
        en = 1'b1; up_dn = 1'b1;
        run(14);

        load_value_now(8'hFF);
        run(5);
        up_dn = 1'b0;
        load_value_now(8'h00);
        run(5);

        en = 1'b0;
        for (int v = 0; v < 16; v++) begin
            load_value_now(W'(v));
            run(6);
        end

        en = 1'b1; up_dn = 1'b1;
        run(3);
        en = 1'b0;
        run(20);
        load_value_now(8'h3C);
        run(4);

        load_value_now(8'h05);
        run(7);
        load_value_now(8'h00);
        run(7);

        en = 1'b1;
        run(4);
        do_reset();
        en = 1'b1; up_dn = 1'b1; load = 1'b0;
        run(14);

        for (int i = 0; i < 1500; i++) begin
            en    = $urandom_range(0, 9) != 0;
            up_dn = $urandom_range(0, 3) != 0;
            load  = $urandom_range(0, 24) == 0;
            case ($urandom_range(0, 3))
                0: load_value = 8'hFF;
                1: load_value = 8'h00;
                default: load_value = W'($urandom);
            endcase
            if (i == 700) do_reset();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_counter.md
# seg7_scan_counter

Parametrised multi-digit hex counter with a time-multiplexed 7-segment display driver, for the icestick PMOD display boards. A prescaler steps an N-digit up/down counter at a fixed rate. A scan engine multiplexes one shared segment bus across N common digit selects. Decode covers all 16 hex digits, with optional leading-zero blanking and anti-ghost blanking between digits.

## Interface
- NUM_DIGITS, 2, number of hex digits, 1..8
- TICK_DIV, 4194304, clk cycles per count step, >= 2
- SCAN_DIV, 12000, clk cycles per digit slot, >= 2
- SEG_ACTIVE_LOW, 1, 1: segment on = 0
- LZ_BLANK, 0, 1: blank leading zero digits
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset, one clock, async assert
- en  in  1  1: prescaler runs; 0: prescaler and count frozen, scan continues
- up_dn  in  1  1: count up, 0: count down
- load  in  1  synchronous load of load_value
- load_value  in  4*NUM_DIGITS  value for load
- count  out  4*NUM_DIGITS  current counter value
- tick  out  1  one-cycle pulse on each count step
- wrap  out  1  one-cycle pulse on counter wrap
- seg  out  7  {g,f,e,d,c,b,a}, a = bit 0, polarity per SEG_ACTIVE_LOW
- dig_sel  out  NUM_DIGITS  one-hot active-high digit enable, bit 0 = least significant digit

## Operation
- Reset values: count=0, prescalers=0, digit index=0, tick=0, wrap=0, dig_sel=0, seg=all off (7'h7F if SEG_ACTIVE_LOW).
- Prescaler: counts 0..TICK_DIV-1 while en=1. At terminal it returns to 0, tick=1, and count steps by ±1 modulo 16^NUM_DIGITS.
- Wrap: up at all-F → 0, or down at 0 → all-F, sets wrap=1 on the same edge as the count update.
- load=1 sets count=load_value and clears the prescaler. It has priority over a step; tick may still pulse, wrap=0. load works even when en=0.
- Scan: the scan counter counts 0..SCAN_DIV-1 continuously, independent of en. At terminal the digit index advances, wrapping from NUM_DIGITS-1 to 0.
- Anti-ghost: during the cycle after the index advances, dig_sel=0 and seg=off. Each following cycle, dig_sel = one-hot(index) and seg = decode(nibble[index]).
- Decode: full 0-9, A, b, C, d, E, F glyphs. Output inversion per SEG_ACTIVE_LOW.
- LZ_BLANK=1: a digit above the most significant nonzero nibble shows seg=off, with dig_sel still driven. Digit 0 is never blanked, so value 0 shows "0".
- NUM_DIGITS=1: index stays 0 and anti-ghost still applies at each scan terminal.

## Timing
- seg and dig_sel are registered, with 1-cycle latency from the index or count change.
- A count change is visible on seg within the same slot, one cycle later.
- tick and wrap are registered and high for exactly one cycle.
- Digit period = NUM_DIGITS*SCAN_DIV cycles. Each slot = 1 blank cycle + SCAN_DIV-1 lit cycles.
- rst_n asserted mid-operation forces all reset values immediately. The first lit output appears 2 cycles after rst_n deasserts: digit 0, showing "0".
- Counter widths are $clog2(TICK_DIV) and $clog2(SCAN_DIV), minimum 1.

## Structure
- Shared package seg7_pkg holds:
  - the 16-entry active-high glyph constant array (bit order gfedcba)
  - SEG_OFF_HI/SEG_OFF_LO constants
  - the digit count limit constant
- Sub-module hex_to_seg7: combinational 4-bit → 7-bit active-high glyph decode, used once on the muxed nibble. Polarity inversion and blanking live in the parent.

## Test plan
All scenarios use NUM_DIGITS=2, TICK_DIV=4, SCAN_DIV=3 unless stated.
- Reset release, en=1, up_dn=1 → tick every 4 cycles; count 00→01→02.
  - Digit 0 lit 2 cycles after release with seg=7'b1000000 (active-low "0").
  - Slots alternate: blank, dig 0, dig 0, blank, dig 1, dig 1.
- load 8'hFF then up step → count=00, wrap=1 for one cycle. Down from 00 → FF, wrap=1.
- Glyph sweep: load each value 0x0..0xF → seg on digit 0 matches the package glyph per nibble, inverted with SEG_ACTIVE_LOW=1.
- en=0 for 20 cycles → count and prescaler frozen, tick=0, scan continues. load=1 with en=0 → count updates.
- LZ_BLANK=1 with count=8'h05 → digit 1 shows seg=off, digit 0 shows "5". With count=8'h00 → digit 0 shows "0".
- rst_n pulsed low mid-slot → all outputs at reset values during the low cycle. Restart matches the first scenario.
